sdp_scan_ctrl: RTL and testbench

Scan scheduler for the multiplexed 8-digit seven-segment display (sdpsel/sdpdisp pins, both active-low).
- Owns a shadow and an active digit-pattern buffer.
- Time-slices the shared segment bus across digits with anti-ghosting blanking and per-slot brightness PWM.
- Accepts pattern writes from one requester over a valid/ready port; commits them tear-free at frame boundaries.
- Sits between application logic (e.g. text/number formatters) and the board display pins.

---
 rtl/sdp_pkg.sv | 39 +++
 rtl/sdp_scan_ctrl_if.sv | 13 +
 rtl/sdp_slot_timer.sv | 70 +++++++
 rtl/sdp_scan_ctrl.sv | 76 +++++++
 tb/tb_sdp_scan_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/sdp_pkg.sv
// rtl/sdp_pkg.sv - shared constants, glyphs and types for the seven-segment scan controller
package sdp_pkg;

    typedef logic [7:0] seg_t;

    // Both sdpsel and sdpdisp are active-low: a 0 bit selects a digit or lights a segment.
    localparam logic PIN_ACTIVE = 1'b0;
    localparam seg_t SEG_BLANK  = 8'hFF;

    // Glyphs are {dp,g,f,e,d,c,b,a}, active-low.
    localparam seg_t GLYPH_0 = 8'hC0;
    localparam seg_t GLYPH_1 = 8'hF9;
    localparam seg_t GLYPH_2 = 8'hA4;
    localparam seg_t GLYPH_3 = 8'hB0;
    localparam seg_t GLYPH_4 = 8'h99;
    localparam seg_t GLYPH_5 = 8'h92;
    localparam seg_t GLYPH_6 = 8'h82;
    localparam seg_t GLYPH_7 = 8'hF8;
    localparam seg_t GLYPH_8 = 8'h80;
    localparam seg_t GLYPH_9 = 8'h90;
    localparam seg_t GLYPH_H = 8'h89;
    localparam seg_t GLYPH_E = 8'h86;
    localparam seg_t GLYPH_L = 8'hC7;
    localparam seg_t GLYPH_O = 8'hC0;

    typedef enum logic [1:0] {
        PH_BLANK = 2'd0,
        PH_ON    = 2'd1,
        PH_OFF   = 2'd2
    } phase_t;

    function automatic seg_t sel_mask(input logic [2:0] d);
        seg_t m;
        m    = SEG_BLANK;
        m[d] = PIN_ACTIVE;
        return m;
    endfunction

endpackage

// File: rtl/sdp_scan_ctrl_if.sv
// rtl/sdp_scan_ctrl_if.sv - pattern write port between a requester and the scan controller
interface sdp_scan_ctrl_if;
    import sdp_pkg::*;

    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    seg_t       wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/sdp_slot_timer.sv
// rtl/sdp_slot_timer.sv - digit slot counters, per-slot on-time and phase decode
module sdp_slot_timer
    import sdp_pkg::*;
#(
    parameter int NDIG      = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dig_en,
    input  logic [3:0] bright,
    output logic [2:0] dig,
    output phase_t     phase,
    output logic       commit,
    output logic       pre_commit
);
    localparam int CNTW = $clog2(SCAN_DIV);
    localparam int MW   = CNTW + 5;

    logic [CNTW-1:0] cnt;
    logic            en_s;
    logic [MW-1:0]   on_len;
    logic [MW-1:0]   len_now;
    logic [MW-1:0]   len_cur;
    logic [MW-1:0]   cnt_w;
    logic            en_cur;
    logic            slot_start;
    logic            last_dig;

    assign slot_start = (cnt == '0);
    assign last_dig   = (dig == 3'(NDIG - 1));
    assign commit     = last_dig && (cnt == CNTW'(SCAN_DIV - 1));
    assign pre_commit = last_dig && (cnt == CNTW'(SCAN_DIV - 2));
    assign len_now    = (MW'(SCAN_DIV - BLANK_CYC) * (MW'(bright) + MW'(1))) >> 4;

    // The slot-start cycle uses the freshly sampled values so the decode is right even with no blanking.
    assign en_cur  = slot_start ? dig_en[dig] : en_s;
    assign len_cur = slot_start ? len_now : on_len;
    assign cnt_w   = MW'(cnt);

    always_comb begin
        phase = PH_OFF;
        if (cnt_w < MW'(BLANK_CYC))
            phase = PH_BLANK;
        else if (en_cur && (cnt_w < MW'(BLANK_CYC) + len_cur))
            phase = PH_ON;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            dig    <= '0;
            en_s   <= 1'b0;
            on_len <= '0;
        end else begin
            if (cnt == CNTW'(SCAN_DIV - 1)) begin
                cnt <= '0;
                dig <= last_dig ? 3'd0 : dig + 3'd1;
            end else begin
                cnt <= cnt + CNTW'(1);
            end
            if (slot_start) begin
                en_s   <= dig_en[dig];
                on_len <= len_now;
            end
        end
    end

endmodule

// File: rtl/sdp_scan_ctrl.sv
// rtl/sdp_scan_ctrl.sv - multiplexed 8-digit seven-segment scan controller with tear-free commits
module sdp_scan_ctrl
    import sdp_pkg::*;
#(
    parameter int NDIG      = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic            clk,
    input  logic            rst,
    sdp_scan_ctrl_if.slave  wr,
    input  logic [7:0]      dig_en,
    input  logic [3:0]      bright,
    output seg_t            sdpsel,
    output seg_t            sdpdisp,
    output logic            frame_tick
);
    seg_t       shadow [8];
    seg_t       active [8];
    logic       dirty;
    logic [2:0] dig;
    phase_t     phase;
    logic       commit;
    logic       pre_commit;

    sdp_slot_timer #(
        .NDIG      (NDIG),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .dig_en     (dig_en),
        .bright     (bright),
        .dig        (dig),
        .phase      (phase),
        .commit     (commit),
        .pre_commit (pre_commit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sdpsel      <= SEG_BLANK;
            sdpdisp     <= SEG_BLANK;
            frame_tick  <= 1'b0;
            wr.wr_ready <= 1'b1;
            dirty       <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= SEG_BLANK;
                active[i] <= SEG_BLANK;
            end
        end else begin
            if (phase == PH_ON) begin
                sdpsel  <= sel_mask(dig);
                sdpdisp <= active[dig];
            end else begin
                sdpsel  <= SEG_BLANK;
                sdpdisp <= SEG_BLANK;
            end
            frame_tick  <= commit;
            // Ready drops exactly on the commit cycle, so a write can never race the buffer copy.
            wr.wr_ready <= !pre_commit;
            if (commit) begin
                if (dirty) begin
                    for (int i = 0; i < 8; i++)
                        active[i] <= shadow[i];
                    dirty <= 1'b0;
                end
            end else if (wr.wr_valid && wr.wr_ready && ({1'b0, wr.wr_addr} < 4'(NDIG))) begin
                shadow[wr.wr_addr] <= wr.wr_data;
                dirty              <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdp_scan_ctrl.sv
// tb/tb_sdp_scan_ctrl.sv - scoreboard bench for sdp_scan_ctrl
module tb_sdp_scan_ctrl;
    import sdp_pkg::*;

    localparam int NDIG      = 5;
    localparam int SCAN_DIV  = 32;
    localparam int BLANK_CYC = 4;
    localparam int FRAME     = NDIG * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dig_en;
    logic [3:0] bright;
    seg_t       sdpsel;
    seg_t       sdpdisp;
    logic       frame_tick;

    sdp_scan_ctrl_if wr_if ();

    sdp_scan_ctrl #(
        .NDIG      (NDIG),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (wr_if),
        .dig_en     (dig_en),
        .bright     (bright),
        .sdpsel     (sdpsel),
        .sdpdisp    (sdpdisp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model, indexed by absolute cycle since reset.
    int         m_t;
    logic       m_en_s;
    int         m_len;
    logic       m_dirty;
    logic       m_ready;
    seg_t       m_shadow [8];
    seg_t       m_active [8];
    logic       xfer;
    int         lit_cnt;
    logic [25:0] sb_q [$];

    task automatic model_step();
        seg_t e_sel, e_disp;
        logic e_tick, e_rdy;
        int   cnt, dig;
        xfer = 1'b0;
        if (rst) begin
            e_sel = 8'hFF; e_disp = 8'hFF; e_tick = 1'b0; e_rdy = 1'b1;
            m_t = 0; m_en_s = 1'b0; m_len = 0; m_dirty = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_shadow[i] = 8'hFF;
                m_active[i] = 8'hFF;
            end
        end else begin
            cnt = m_t % SCAN_DIV;
            dig = (m_t / SCAN_DIV) % NDIG;
            if (cnt == 0) begin
                m_en_s = dig_en[dig];
                m_len  = ((SCAN_DIV - BLANK_CYC) * (int'(bright) + 1)) / 16;
            end
            e_sel  = 8'hFF;
            e_disp = 8'hFF;
            if (cnt >= BLANK_CYC && cnt < BLANK_CYC + m_len && m_en_s) begin
                e_sel[dig] = 1'b0;
                e_disp     = m_active[dig];
            end
            e_tick = (m_t % FRAME) == FRAME - 1;
            e_rdy  = (m_t % FRAME) != FRAME - 2;
            if (wr_if.wr_valid && m_ready) begin
                xfer = 1'b1;
                if (int'(wr_if.wr_addr) < NDIG) begin
                    m_shadow[wr_if.wr_addr] = wr_if.wr_data;
                    m_dirty = 1'b1;
                end
            end
            if (e_tick && m_dirty) begin
                for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
                m_dirty = 1'b0;
            end
            m_t++;
        end
        m_ready = e_rdy;
        sb_q.push_back({e_rdy, e_tick, e_sel, e_disp});
    endtask

    task automatic tick();
        logic [25:0] exp;
        model_step();
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        check_eq("pins", {6'd0, wr_if.wr_ready, frame_tick, sdpsel, sdpdisp}, {6'd0, exp});
        if (sdpsel != 8'hFF) lit_cnt++;
    endtask

    task automatic wait_tick();
        int   k;
        logic seen;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 2 * FRAME) begin
            tick();
            k++;
            if (frame_tick) seen = 1'b1;
        end
        check_eq("frame_tick_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic run_frame(output int lit);
        wait_tick();
        lit_cnt = 0;
        repeat (FRAME) tick();
        lit = lit_cnt;
    endtask

    task automatic do_write(input logic [2:0] addr, input seg_t data, output int n);
        logic done;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = addr;
        wr_if.wr_data  = data;
        n    = 0;
        done = 1'b0;
        while (!done && n < 50) begin
            tick();
            n++;
            if (xfer) done = 1'b1;
        end
        wr_if.wr_valid = 1'b0;
        check_eq("wr_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int   lit, n, t1, t2;
        seg_t pat [5];
        pat[0] = GLYPH_H; pat[1] = GLYPH_E; pat[2] = GLYPH_L; pat[3] = GLYPH_L; pat[4] = 8'hA3;

        rst = 1'b1;
        dig_en = 8'h00;
        bright = 4'd15;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_addr  = 3'd0;
        wr_if.wr_data  = 8'hFF;
        tick();
        tick();
        rst = 1'b0;

        // Idle: dark pins, frame_tick every FRAME cycles.
        t1 = -1; t2 = -1;
        lit_cnt = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (frame_tick) begin
                if (t1 < 0) t1 = i; else t2 = i;
            end
        end
        check_eq("s1_first_tick", t1, FRAME - 1);
        check_eq("s1_tick_period", t2 - t1, FRAME);
        check_eq("s1_lit", lit_cnt, 0);

        // Full brightness with HELLo.
        dig_en = 8'h1F;
        for (int i = 0; i < 5; i++) do_write(3'(i), pat[i], n);
        run_frame(lit);
        check_eq("s2_lit_b15", lit, NDIG * (SCAN_DIV - BLANK_CYC));

        bright = 4'd3;
        run_frame(lit);
        check_eq("s3_lit_b3", lit, NDIG * 7);
        bright = 4'd0;
        run_frame(lit);
        check_eq("s3_lit_b0", lit, NDIG * 1);

        bright = 4'd15;
        dig_en = 8'h1B;
        run_frame(lit);
        check_eq("s4_lit_dis2", lit, 4 * (SCAN_DIV - BLANK_CYC));
        check_eq("s4_period_tick", {31'd0, frame_tick}, 32'd1);

        // Write held across the commit cycle.
        wait_tick();
        repeat (FRAME - 1) tick();
        check_eq("s5_ready_low", {31'd0, wr_if.wr_ready}, 32'd0);
        do_write(3'd1, 8'hC0, n);
        check_eq("s5_stall_cycles", n, 2);
        run_frame(lit);
        do_write(3'd6, 8'h00, n);
        check_eq("s5_addr6_cycles", n, 1);
        run_frame(lit);
        check_eq("s5_lit", lit, 4 * (SCAN_DIV - BLANK_CYC));

        // Reset mid-frame at dig 3, cnt 10.
        wait_tick();
        repeat (3 * SCAN_DIV + 10) tick();
        check_eq("s6_pre_cnt", dut.u_timer.cnt, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("s6_cnt", dut.u_timer.cnt, 0);
        check_eq("s6_dig", dut.u_timer.dig, 0);
        for (int i = 0; i < 8; i++) begin
            check_eq("s6_active", dut.active[i], 8'hFF);
            check_eq("s6_shadow", dut.shadow[i], 8'hFF);
        end
        dig_en = 8'h1F;
        run_frame(lit);
        check_eq("s6_lit", lit, NDIG * (SCAN_DIV - BLANK_CYC));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
